// File: rtl/cla8_seq_addsub.sv
// Multi-cycle WIDTH-bit add/subtract that time-shares a single 8-bit carry-lookahead adder,
// processing one byte per cycle LSB first with a registered inter-chunk carry.

module cla8 (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic       cin_i,
  output logic [7:0] sum_o,
  output logic       cout_o
);
  logic [7:0] g;
  logic [7:0] p;
  logic [8:0] c;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  // Carry into bit n as a flat sum of products over generate/propagate terms.
  function automatic logic lookahead(input logic [7:0] gen, input logic [7:0] prop,
                                     input logic cin, input int n);
    logic acc;
    logic run;
    acc = 1'b0;
    run = 1'b1;
    for (int j = n - 1; j >= 0; j--) begin
      acc = acc | (run & gen[j]);
      run = run & prop[j];
    end
    return acc | (run & cin);
  endfunction

  assign c[0] = cin_i;

  for (genvar gi = 0; gi < 8; gi++) begin : g_bit
    assign c[gi+1]   = lookahead(g, p, cin_i, gi + 1);
    assign sum_o[gi] = p[gi] ^ c[gi];
  end

  assign cout_o = c[8];
endmodule

module cla8_seq_addsub #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  localparam int NCHUNK = WIDTH / 8;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               a_msb_q, a_msb_d;
  logic               b_msb_q, b_msb_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic               zero_q, zero_d;

  logic [WIDTH-1:0]   b_prime;
  logic [7:0]         cla_sum;
  logic               cla_cout;
  logic [WIDTH-1:0]   byte_ext;
  logic [WIDTH-1:0]   res_next;

  assign b_prime = op_sub ? ~b : b;

  cla8 u_cla8 (
    .a_i    (a_sh_q[7:0]),
    .b_i    (b_sh_q[7:0]),
    .cin_i  (carry_q),
    .sum_o  (cla_sum),
    .cout_o (cla_cout)
  );

  // New byte enters at the top so after NCHUNK passes the result is in place.
  always_comb begin
    byte_ext      = '0;
    byte_ext[7:0] = cla_sum;
    res_next      = (res_q >> 8) | (byte_ext << (WIDTH - 8));
  end

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sh_d  = a;
          b_sh_d  = b_prime;
          carry_d = op_sub;
          cnt_d   = '0;
          a_msb_d = a[WIDTH-1];
          b_msb_d = b_prime[WIDTH-1];
          state_d = RUN;
        end
      end
      RUN: begin
        res_d   = res_next;
        a_sh_d  = a_sh_q >> 8;
        b_sh_d  = b_sh_q >> 8;
        carry_d = cla_cout;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(NCHUNK - 1)) begin
          sum_d   = res_next;
          cout_d  = cla_cout;
          ovf_d   = (a_msb_q == b_msb_q) && (res_next[WIDTH-1] != a_msb_q);
          zero_d  = (res_next == '0);
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;
endmodule

// File: tb/tb_cla8_seq_addsub.sv
// Randomized and directed checks of cla8_seq_addsub against a plain-arithmetic model,
// including latency, backpressure, busy-period input noise and reset mid-operation.

module tb_cla8_seq_addsub;
  localparam int WIDTH  = 32;
  localparam int NCHUNK = WIDTH / 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic             op_sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  int n_chk  = 0;
  int n_fail = 0;

  cla8_seq_addsub #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_sub    (op_sub),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain two's-complement arithmetic and signed range test.
  task automatic model(input logic [31:0] x, input logic [31:0] y, input logic s,
                       output logic [31:0] r, output logic c, output logic v);
    longint sx;
    longint sy;
    longint sr;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    sr = s ? (sx - sy) : (sx + sy);
    r  = s ? (x - y) : (x + y);
    c  = s ? (x >= y) : (((64'(x) + 64'(y)) >> 32) != 64'd0);
    v  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
  endtask

  task automatic run_op(input logic [31:0] xa, input logic [31:0] xb, input logic xs,
                        input int hold, input bit noise);
    logic [31:0] er;
    logic        ec;
    logic        ev;
    logic [31:0] held;
    int          lat;
    model(xa, xb, xs, er, ec, ev);
    @(negedge clk);
    chk("in_ready_idle", 64'(in_ready), 64'd1);
    a = xa; b = xb; op_sub = xs; in_valid = 1'b1; out_ready = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (!out_valid) chk("in_ready_busy", 64'(in_ready), 64'd0);
      in_valid = (noise && !out_valid) ? 1'($urandom_range(0, 1)) : 1'b0;
      a = $urandom; b = $urandom; op_sub = 1'($urandom);
    end while (!out_valid && lat < 20);
    in_valid = 1'b0;
    chk("latency", 64'(lat), 64'(NCHUNK + 1));
    chk("sum", 64'(sum), 64'(er));
    chk("cout", 64'(cout), 64'(ec));
    chk("ovf", 64'(ovf), 64'(ev));
    chk("zero", 64'(zero), 64'(er == 32'd0));
    $display("op a=%08h b=%08h sub=%0d -> sum=%08h cout=%0d ovf=%0d zero=%0d lat=%0d hold=%0d",
             xa, xb, xs, sum, cout, ovf, zero, lat, hold);
    held = sum;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_sum", 64'(sum), 64'(held));
      chk("hold_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("post_valid", 64'(out_valid), 64'd0);
    chk("post_in_ready", 64'(in_ready), 64'd1);
    chk("post_sum_kept", 64'(sum), 64'(er));
  endtask

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic        s;
    int          hold;
    bit          noise;
  } vec_t;

  vec_t dir[$];

  initial begin
    rst = 1'b1; in_valid = 1'b0; op_sub = 1'b0; a = '0; b = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_flags", {61'd0, cout, ovf, zero}, 64'd0);

    dir.push_back('{32'h000000FF, 32'h00000001, 1'b0, 0, 1'b0});
    dir.push_back('{32'hFFFFFFFF, 32'h00000001, 1'b0, 0, 1'b0});
    dir.push_back('{32'h00000005, 32'h00000007, 1'b1, 0, 1'b0});
    dir.push_back('{32'h00000007, 32'h00000005, 1'b1, 0, 1'b0});
    dir.push_back('{32'h7FFFFFFF, 32'h00000001, 1'b0, 0, 1'b0});
    dir.push_back('{32'h80000000, 32'h00000001, 1'b1, 0, 1'b0});
    dir.push_back('{32'h12345678, 32'h12345678, 1'b1, 10, 1'b1});
    foreach (dir[i]) run_op(dir[i].x, dir[i].y, dir[i].s, dir[i].hold, dir[i].noise);

    // Reset during RUN chunk 2 aborts the operation.
    @(negedge clk);
    a = 32'hDEADBEEF; b = 32'h01010101; op_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_sum", 64'(sum), 64'd0);
    $display("reset mid-op: in_ready=%0d out_valid=%0d sum=%08h", in_ready, out_valid, sum);
    run_op(32'h12345678, 32'h11111111, 1'b0, 0, 1'b0);

    for (int k = 0; k < 40; k++) begin
      logic [31:0] rx;
      logic [31:0] ry;
      rx = $urandom;
      ry = (k % 8 == 0) ? rx : $urandom;
      run_op(rx, ry, 1'($urandom), int'($urandom_range(0, 3)), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
